// File: rtl/mem_copy_pkg.sv
// Shared types and helpers for the block-copy engine.
// Direction choice lives here so callers and tests agree on it.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } copy_state_t;

  // Descend when the destination starts inside the source window,
  // measured forward from src with wrap at 2**aw.
  function automatic logic overlap_desc(
    input logic [31:0] src,
    input logic [31:0] dst,
    input logic [31:0] len,
    input int          aw
  );
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << aw) - 32'd1;
    diff = (dst - src) & mask;
    return (dst != src) && (diff < len);
  endfunction

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Source/destination cursors for the copy engine.
// Loaded at start, stepped on each committed write.
module mem_copy_addr_gen #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          desc,
  input  logic          wr,
  input  logic          hold,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] last_off,
  output logic [AW-1:0] cur_src,
  output logic [AW-1:0] cur_dst
);

  logic desc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      desc_q  <= 1'b0;
      cur_src <= '0;
      cur_dst <= '0;
    end else if (load) begin
      desc_q  <= desc;
      cur_src <= desc ? src + last_off : src;
      cur_dst <= desc ? dst + last_off : dst;
    end else if (wr && !hold) begin
      cur_src <= desc_q ? cur_src - 1'b1 : cur_src + 1'b1;
      cur_dst <= desc_q ? cur_dst - 1'b1 : cur_dst + 1'b1;
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the data memory, memmove semantics.
// One word moves every RD/WR pair; hold pauses it in place.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DM_ADDRESS-1:0] src_addr,
  input  logic [DM_ADDRESS-1:0] dst_addr,
  input  logic [DM_ADDRESS:0]   len,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic [DM_ADDRESS:0]   count,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  localparam logic [DM_ADDRESS:0] DEPTH =
    {1'b1, {DM_ADDRESS{1'b0}}};

  copy_state_t           state;
  logic [DM_ADDRESS:0]   len_q;
  logic [DM_ADDRESS:0]   len_sat;
  logic [DM_ADDRESS:0]   count_nx;
  logic [DATA_W-1:0]     buf_q;
  logic [DM_ADDRESS-1:0] a_q;
  logic [DM_ADDRESS-1:0] cur_src;
  logic [DM_ADDRESS-1:0] cur_dst;
  logic [DM_ADDRESS-1:0] last_off;
  logic                  load;
  logic                  desc;

  assign len_sat  = (len > DEPTH) ? DEPTH : len;
  assign last_off = len_sat[DM_ADDRESS-1:0] - 1'b1;
  assign desc     = overlap_desc(32'(src_addr), 32'(dst_addr),
                                 32'(len_sat), DM_ADDRESS);
  assign load     = (state == IDLE) && start;
  assign count_nx = count + 1'b1;

  mem_copy_addr_gen #(
    .AW(DM_ADDRESS)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .desc    (desc),
    .wr      (state == WR),
    .hold    (hold),
    .src     (src_addr),
    .dst     (dst_addr),
    .last_off(last_off),
    .cur_src (cur_src),
    .cur_dst (cur_dst)
  );

  always_comb begin
    a = a_q;
    if (state == RD) a = cur_src;
    else if (state == WR) a = cur_dst;
  end

  assign MemRead  = (state == RD) && !hold;
  assign MemWrite = (state == WR) && !hold;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wd       = buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
      buf_q <= '0;
      a_q   <= '0;
    end else begin
      a_q <= a;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_sat;
            count <= '0;
            state <= (len_sat == '0) ? DONE : RD;
          end
        end
        RD: begin
          if (!hold) begin
            buf_q <= rd;
            state <= WR;
          end
        end
        WR: begin
          if (!hold) begin
            count <= count_nx;
            state <= (count_nx == len_q) ? DONE : RD;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a memmove model.
// Memory is a 512-word array written at posedge like the real RAM.
module tb_mem_copy_engine;

  localparam int M = 512;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [9:0]  len;
  logic        hold;
  logic        busy;
  logic        done;
  logic [9:0]  count;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;

  logic [31:0] mem   [M];
  logic [31:0] old_m [M];
  logic [31:0] exp_m [M];

  logic        tb_we;
  logic [8:0]  tb_wa;
  logic [31:0] tb_wd;

  int n_chk;
  int n_fail;

  int r_done_cyc, r_nrd, r_nwr, r_fwa, r_both;
  int r_busy, r_pulses, r_holdbad, r_cnt;

  mem_copy_engine dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .a       (a),
    .wd      (wd),
    .rd      (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd = mem[a];

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (MemWrite) mem[a] <= wd;
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input int ad, input logic [31:0] v);
    tb_we = 1'b1;
    tb_wa = 9'(ad);
    tb_wd = v;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  // Reference: every destination word takes the pre-copy source word.
  task automatic model(input int s, input int d, input int n);
    for (int i = 0; i < M; i++) begin
      old_m[i] = mem[i];
      exp_m[i] = mem[i];
    end
    for (int i = 0; i < n; i++)
      exp_m[(d + i) % M] = old_m[(s + i) % M];
  endtask

  task automatic cmp_mem(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < M; i++)
      if (mem[i] !== exp_m[i]) nb++;
    chk(tag, nb, 0);
  endtask

  function automatic int exp_fwa(input int s, input int d, input int n);
    int off;
    off = (d - s + M) % M;
    if (d != s && off < n) return (d + n - 1) % M;
    return d;
  endfunction

  task automatic run_copy(input int s, input int d, input int l,
                          input int hs, input int hn,
                          input int rc, input int sc);
    bit fin;
    r_done_cyc = -1; r_nrd = 0; r_nwr = 0; r_fwa = -1;
    r_both = 0; r_busy = 0; r_pulses = 0; r_holdbad = 0;
    r_cnt = -1;
    src_addr = 9'(s);
    dst_addr = 9'(d);
    len = 10'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_addr = 9'($urandom);
    dst_addr = 9'($urandom);
    len = 10'($urandom);
    fin = 1'b0;
    for (int c = 1; c <= 1200 && !fin; c++) begin
      hold  = (c >= hs) && (c < hs + hn);
      reset = (c == rc);
      start = (c == sc);
      @(negedge clk);
      if (busy) r_busy++;
      if (done) begin
        r_pulses++;
        r_done_cyc = c;
        r_cnt = int'(count);
      end
      if (MemRead) r_nrd++;
      if (MemWrite) begin
        r_nwr++;
        if (r_fwa < 0) r_fwa = int'(a);
      end
      if (MemRead && MemWrite) r_both++;
      if (hold && (MemRead || MemWrite)) r_holdbad++;
      if (!busy) fin = 1'b1;
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    chk("bounded_finish", fin, 1);
  endtask

  initial begin
    int n, s, d, hs, hn, off;
    n_chk = 0;
    n_fail = 0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", {MemRead, MemWrite}, 0);
    chk("rst_a", a, 0);
    chk("rst_wd", wd, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    for (int i = 0; i < M; i++) poke(i, $urandom);

    poke(10, 32'hA000_000A); poke(11, 32'hB000_000B);
    poke(12, 32'hC000_000C); poke(13, 32'hD000_000D);
    model(10, 100, 4);
    run_copy(10, 100, 4, 0, 0, -1, -1);
    chk("basic_done_cyc", r_done_cyc, 9);
    chk("basic_busy", r_busy, 9);
    chk("basic_count", r_cnt, 4);
    chk("basic_access", r_nrd + r_nwr, 8);
    chk("basic_pulses", r_pulses, 1);
    chk("basic_both", r_both, 0);
    cmp_mem("basic_mem");
    chk("basic_word103", mem[103], 32'hD000_000D);

    model(50, 60, 0);
    run_copy(50, 60, 0, 0, 0, -1, -1);
    chk("zero_done_cyc", r_done_cyc, 1);
    chk("zero_busy", r_busy, 1);
    chk("zero_access", r_nrd + r_nwr, 0);
    cmp_mem("zero_mem");

    poke(20, 1); poke(21, 2); poke(22, 3); poke(23, 4);
    model(20, 22, 4);
    run_copy(20, 22, 4, 0, 0, -1, -1);
    chk("ovl_first_wa", r_fwa, 25);
    cmp_mem("ovl_mem");
    chk("ovl_word25", mem[25], 4);

    model(510, 0, 4);
    run_copy(510, 0, 4, 0, 0, -1, -1);
    chk("wrap_first_wa", r_fwa, 3);
    chk("wrap_reads", r_nrd, 4);
    cmp_mem("wrap_mem");

    model(10, 200, 4);
    run_copy(10, 200, 4, 2, 3, -1, -1);
    chk("hold_done_cyc", r_done_cyc, 12);
    chk("hold_quiet", r_holdbad, 0);
    chk("hold_writes", r_nwr, 4);
    chk("hold_first_wa", r_fwa, 200);
    cmp_mem("hold_mem");

    model(40, 60, 1);
    run_copy(40, 60, 8, 0, 0, 3, -1);
    chk("rst_mid_pulses", r_pulses, 0);
    chk("rst_mid_busy", r_busy, 3);
    chk("rst_mid_count", count, 0);
    cmp_mem("rst_mid_mem");

    model(300, 330, 6);
    run_copy(300, 330, 6, 0, 0, -1, 5);
    chk("sbusy_done_cyc", r_done_cyc, 13);
    chk("sbusy_pulses", r_pulses, 1);
    cmp_mem("sbusy_mem");

    model(7, 7, 512);
    run_copy(7, 7, 700, 0, 0, -1, -1);
    chk("sat_done_cyc", r_done_cyc, 1025);
    chk("sat_count", r_cnt, 512);
    chk("sat_first_wa", r_fwa, 7);
    cmp_mem("sat_mem");

    for (int t = 0; t < 20; t++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 48));
      if (t == 19) n = 200;
      s = int'($urandom_range(0, M - 1));
      if ($urandom_range(0, 1) == 1) begin
        off = int'($urandom_range(0, 2 * n + 2)) - n - 1;
        d = (s + M + off) % M;
      end else begin
        d = int'($urandom_range(0, M - 1));
      end
      hs = (n > 0) ? int'($urandom_range(1, 2 * n)) : 0;
      hn = (n > 0) ? int'($urandom_range(0, 3)) : 0;
      model(s, d, n);
      run_copy(s, d, n, hs, hn, -1, -1);
      chk("rnd_done_cyc", r_done_cyc, 2 * n + 1 + hn);
      chk("rnd_count", r_cnt, n);
      chk("rnd_access", r_nrd + r_nwr, 2 * n);
      chk("rnd_both", r_both, 0);
      chk("rnd_hold", r_holdbad, 0);
      if (n > 0) chk("rnd_first_wa", r_fwa, exp_fwa(s, d, n));
      cmp_mem("rnd_mem");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
